// File: rtl/antitheft_timer.sv
// antitheft_timer
//   Whole-second countdown timer used by the anti-theft control FSM. It also
//   produces the system one_hz_enable tick. The FSM picks one of four intervals
//   and pulses start_timer. This block then counts that many seconds and
//   pulses expired once the count ends. The four delays can be reprogrammed at
//   run time. Each delay is 4 bits wide, in seconds.
//
// Ports
//   clock           in   1  system clock, rising edge
//   reset           in   1  synchronous reset, active low
//   interval        in   2  interval select, sampled with start_timer
//   start_timer     in   1  one-cycle request: load interval and start counting
//   reprogram       in   1  write time_value into delay slot time_param_sel
//   time_param_sel  in   2  delay slot to write (same encoding as interval)
//   time_value      in   4  new delay in seconds
//   expired         out  1  one-cycle pulse when the countdown ends
//   one_hz_enable   out  1  one-cycle tick every CLK_HZ cycles
//   busy            out  1  high while counting
//   time_remaining  out  4  seconds left, 0 when not counting
//
// State table
//   state   | meaning
//   IDLE    | waiting for start_timer
//   COUNT   | counting seconds down, busy=1
//   EXPIRED | single-cycle expired pulse

module antitheft_timer #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int T_ARM_DEF   = 6,
    parameter int T_DRV_DEF   = 8,
    parameter int T_PASS_DEF  = 15,
    parameter int T_ALARM_DEF = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] interval,
    input  logic       start_timer,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       one_hz_enable,
    output logic       busy,
    output logic [3:0] time_remaining
);

    localparam int DIV_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    localparam logic [3:0] ARM_DEF   = 4'(T_ARM_DEF);
    localparam logic [3:0] DRV_DEF   = 4'(T_DRV_DEF);
    localparam logic [3:0] PASS_DEF  = 4'(T_PASS_DEF);
    localparam logic [3:0] ALARM_DEF = 4'(T_ALARM_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [3:0]       count;
    logic [3:0]       params [0:3];

    logic       start_ok;
    logic [3:0] sel_value;

    // Reprogram has priority over a start in the same cycle.
    assign start_ok  = start_timer & ~reprogram;
    assign sel_value = params[interval];

    assign one_hz_enable  = (div == DIV_MAX);
    assign expired        = (state == EXPIRED);
    assign busy           = (state == COUNT);
    assign time_remaining = count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            div       <= '0;
            count     <= '0;
            params[0] <= ARM_DEF;
            params[1] <= DRV_DEF;
            params[2] <= PASS_DEF;
            params[3] <= ALARM_DEF;
        end else begin
            // A start clears the divider, so the first second after the
            // start is a full CLK_HZ cycles long.
            if (start_ok || div == DIV_MAX) begin
                div <= '0;
            end else begin
                div <= div + DIV_ONE;
            end

            if (reprogram) begin
                params[time_param_sel] <= time_value;
                state                  <= IDLE;
                count                  <= '0;
            end else if (start_timer) begin
                // A start is accepted in every state. A start during COUNT
                // or EXPIRED drops the old countdown without pulsing expired.
                if (sel_value == 4'd0) begin
                    state <= EXPIRED;
                    count <= '0;
                end else begin
                    state <= COUNT;
                    count <= sel_value;
                end
            end else begin
                case (state)
                    COUNT: begin
                        if (one_hz_enable) begin
                            // The count is always >= 1 while in COUNT. The
                            // last second moves straight to EXPIRED with
                            // count 0, so the count never underflows.
                            if (count <= 4'd1) begin
                                state <= EXPIRED;
                                count <= '0;
                            end else begin
                                count <= count - 4'd1;
                            end
                        end
                    end
                    EXPIRED: begin
                        state <= IDLE;
                        count <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
